// File: rtl/bs_serializer_pkg.sv
// Shared definitions for the bit-serial datapath blocks (serializer, adder,
// and the planned deserializer).
//   bs_state_t    : shifter state encoding (BS_IDLE, BS_SHIFT)
//   bs_cnt_width  : counter width needed to count 0..frame-1 (never below 1)
package bs_serializer_pkg;

  typedef enum logic {
    BS_IDLE  = 1'b0,
    BS_SHIFT = 1'b1
  } bs_state_t;

  function automatic int bs_cnt_width(input int frame);
    return (frame > 2) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/bs_frame_cnt.sv
// Modulo-FRAME bit counter for bit-serial frames.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset (counter -> 0)
//   start  in  begin a new frame: counter -> 0
//   clear  in  abandon / finish the frame: counter -> 0
//   en     in  advance the counter, wrapping FRAME-1 -> 0
//   last   out counter == FRAME-1
//   first  out counter == 0
module bs_frame_cnt
  import bs_serializer_pkg::*;
#(
  parameter int FRAME = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  input  logic en,
  output logic last,
  output logic first
);

  localparam int CW = bs_cnt_width(FRAME);
  localparam logic [CW-1:0] LAST_VAL = CW'(FRAME - 1);
  localparam logic [CW-1:0] ZERO_VAL = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_VAL  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Bit position counter: restart on start/clear, otherwise wrap at FRAME-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO_VAL;
    end else if (start || clear) begin
      cnt_r <= ZERO_VAL;
    end else if (en) begin
      cnt_r <= (cnt_r == LAST_VAL) ? ZERO_VAL : (cnt_r + ONE_VAL);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last  = (cnt_r == LAST_VAL);
  assign first = (cnt_r == ZERO_VAL);

endmodule

// File: rtl/bs_serializer.sv
// Parallel-to-bit-serial converter. Each accepted WIDTH-bit word is sent
// LSB-first as a frame of FRAME = WIDTH+PAD cycles; the PAD trailing bits are
// zero so a downstream bit-serial adder has room for its carry-out. A one-entry
// hold register lets back-to-back words stream with no gap between frames.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   in_data   in   parallel word, bit 0 = LSB
//   in_valid  in   in_data valid
//   in_ready  out  hold register free (registered); transfer on in_valid & in_ready
//   q         out  serial data (registered)
//   osync     out  high on the cycle q carries bit 0 of a frame
//   busy      out  a frame is in progress or a word is held (registered)
module bs_serializer
  import bs_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PAD   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             q,
  output logic             osync,
  output logic             busy
);

  localparam int FRAME = WIDTH + PAD;

  bs_state_t        state_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full_r;
  logic             q_r;
  logic             busy_r;
  logic             in_ready_r;

  logic accept_s;
  logic shifting_s;
  logic last_s;
  logic first_s;
  logic free_s;
  logic load_s;
  logic go_idle_s;

  assign accept_s   = in_valid & in_ready_r;
  assign shifting_s = (state_r == BS_SHIFT);
  // The shifter can take a new word on its final frame cycle, which is what
  // makes back-to-back frames gap-free.
  assign free_s     = ~shifting_s | last_s;
  // in_ready mirrors !hold_full, so an accept never coincides with a full hold.
  assign load_s     = free_s & (hold_full_r | accept_s);
  assign go_idle_s  = free_s & ~load_s;

  bs_frame_cnt #(
    .FRAME (FRAME)
  ) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .start (load_s),
    .clear (go_idle_s),
    .en    (shifting_s),
    .last  (last_s),
    .first (first_s)
  );

  // Shifter, hold register and handshake state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= BS_IDLE;
      shift_r     <= {WIDTH{1'b0}};
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
      q_r         <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
    end else if (free_s) begin
      if (hold_full_r) begin
        // Held word moves into the shifter; hold frees up next cycle.
        state_r     <= BS_SHIFT;
        shift_r     <= hold_r;
        q_r         <= hold_r[0];
        hold_r      <= hold_r;
        hold_full_r <= 1'b0;
        busy_r      <= 1'b1;
        in_ready_r  <= 1'b1;
      end else if (accept_s) begin
        // Fresh word goes straight to the shifter; hold stays empty.
        state_r     <= BS_SHIFT;
        shift_r     <= in_data;
        q_r         <= in_data[0];
        hold_r      <= hold_r;
        hold_full_r <= 1'b0;
        busy_r      <= 1'b1;
        in_ready_r  <= 1'b1;
      end else begin
        state_r     <= BS_IDLE;
        shift_r     <= shift_r;
        q_r         <= 1'b0;
        hold_r      <= hold_r;
        hold_full_r <= 1'b0;
        busy_r      <= 1'b0;
        in_ready_r  <= 1'b1;
      end
    end else begin
      // Mid-frame: shift right with zero fill, so pad bits come out as 0.
      state_r <= BS_SHIFT;
      shift_r <= {1'b0, shift_r[WIDTH-1:1]};
      q_r     <= shift_r[1];
      busy_r  <= 1'b1;
      if (accept_s) begin
        hold_r      <= in_data;
        hold_full_r <= 1'b1;
        in_ready_r  <= 1'b0;
      end else begin
        hold_r      <= hold_r;
        hold_full_r <= hold_full_r;
        in_ready_r  <= ~hold_full_r;
      end
    end
  end

  assign q        = q_r;
  assign busy     = busy_r;
  assign in_ready = in_ready_r;
  // Decoded purely from flops (state and counter), no input-to-output path.
  assign osync    = shifting_s & first_s;

endmodule

// File: tb/tb_bs_serializer.sv
module tb_bs_serializer;

  localparam int WIDTH = 8;
  localparam int PAD   = 1;
  localparam int FRAME = WIDTH + PAD;
  localparam int MAXC  = 40000;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             q;
  logic             osync;
  logic             busy;

  always #5 clk = ~clk;

  bs_serializer #(.WIDTH(WIDTH), .PAD(PAD)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q        (q),
    .osync    (osync),
    .busy     (busy)
  );

  // Per-cycle expectations, derived from frame-start arithmetic.
  bit eq [MAXC];
  bit es [MAXC];
  bit eb [MAXC];
  bit er [MAXC];
  int cyc;
  int next_free;
  int checks;
  int errors;
  int sync_seen[$];

  typedef struct {
    bit             v;
    logic [7:0]     d;
    bit             xq;
    bit             xs;
    bit             xb;
    bit             xr;
  } vec_t;
  vec_t tbl[11];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic clear_exp(input int c0, input int c1);
    for (int c = c0; c <= c1 && c < MAXC; c++) begin
      eq[c] = 1'b0; es[c] = 1'b0; eb[c] = 1'b0; er[c] = 1'b1;
    end
  endtask

  // A word accepted at t starts its frame as soon as the previous frame ends.
  task automatic model_accept(input int t, input logic [7:0] d);
    int s;
    s = (t + 1 > next_free) ? t + 1 : next_free;
    for (int i = 0; i < FRAME; i++) begin
      eq[s+i] = (i < WIDTH) ? d[i] : 1'b0;
      es[s+i] = (i == 0);
      eb[s+i] = 1'b1;
    end
    for (int c = t + 1; c < s; c++) begin
      er[c] = 1'b0;
      eb[c] = 1'b1;
    end
    next_free = s + FRAME;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    in_valid = v; in_data = d; reset = r;
    @(negedge clk);
    if (osync === 1'b1) sync_seen.push_back(cyc);
  endtask

  task automatic model_check();
    check1("q", q, eq[cyc]);
    check1("osync", osync, es[cyc]);
    check1("busy", busy, eb[cyc]);
    check1("in_ready", in_ready, er[cyc]);
  endtask

  task automatic finish_cycle(input logic v, input logic [7:0] d, input logic r);
    if (r) begin
      clear_exp(cyc + 1, cyc + 2 * FRAME + 4);
      er[cyc+1] = 1'b0;
      next_free = 0;
    end else if (v && er[cyc]) begin
      model_accept(cyc, d);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r, input bit chk);
    drive(v, d, r);
    if (chk) model_check();
    finish_cycle(v, d, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Offer one word with in_valid held until the modelled handshake takes it.
  task automatic offer(input logic [7:0] d);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      done = er[cyc];
      step(1'b1, d, 1'b0, 1'b1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL offer_timeout cycle %0d: word %h not accepted, expected accept within 40 cycles", cyc, d);
    end
  endtask

  initial begin
    int base;
    int accepted;
    bit v;
    bit r;
    logic [7:0] d;
    checks = 0; errors = 0; cyc = 0; next_free = 0;
    clear_exp(0, MAXC - 1);
    in_valid = 1'b0; in_data = 8'h00; reset = 1'b1;

    // Reset, then one cycle with in_ready still low.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Test 1 as an explicit vector table: 0xA5 accepted at cycle 0.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].d, 1'b0);
      check1("tbl_q", q, tbl[i].xq);
      check1("tbl_osync", osync, tbl[i].xs);
      check1("tbl_busy", busy, tbl[i].xb);
      check1("tbl_in_ready", in_ready, tbl[i].xr);
      model_check();
      finish_cycle(tbl[i].v, tbl[i].d, 1'b0);
    end
    idle(3);

    // Test 2: three words back-to-back, osync every FRAME cycles.
    sync_seen.delete();
    base = cyc;
    offer(8'h01);
    offer(8'hFF);
    offer(8'h80);
    idle(2 * FRAME + 2);
    checks++;
    if (sync_seen.size() != 3) begin
      errors++;
      $display("FAIL stream_sync_count: got %0d pulses expected 3", sync_seen.size());
    end else begin
      check1("stream_sync0", (sync_seen[0] == base + 1), 1'b1);
      check1("stream_sync1", (sync_seen[1] == base + 1 + FRAME), 1'b1);
      check1("stream_sync2", (sync_seen[2] == base + 1 + 2 * FRAME), 1'b1);
    end

    // Test 3: frame end coincides with a fresh accept, hold empty.
    base = cyc;
    step(1'b1, 8'h0F, 1'b0, 1'b1);
    idle(8);
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check1("adj_osync", osync, 1'b1);
    check1("adj_q_bit0", q, 1'b0);
    check1("adj_in_ready", in_ready, 1'b1);
    model_check();
    finish_cycle(1'b0, 8'h00, 1'b0);
    idle(FRAME + 2);

    // Test 4: reset in cycle 4 of a 0x3C frame with 0xC3 held.
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check1("rst_q", q, 1'b0);
    check1("rst_osync", osync, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    finish_cycle(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check1("rst_ready_back", in_ready, 1'b1);
    model_check();
    finish_cycle(1'b0, 8'h00, 1'b0);
    idle(2 * FRAME);

    // Test 6: random traffic with occasional resets against the model.
    accepted = 0;
    while (accepted < 1500 && cyc < MAXC - 4 * FRAME) begin
      v = ($urandom_range(0, 99) < 60);
      d = 8'($urandom);
      r = ($urandom_range(0, 1999) == 0);
      if (v && !r && er[cyc]) accepted++;
      step(v, d, r, 1'b1);
    end
    idle(2 * FRAME + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
